// File: rtl/bf16_norm_pack.sv
// bf16_norm_pack: back end of the bfloat16 adder.
// Takes the 11-bit significand sum with its sign and exponent from the add stage.
// Normalizes the sum one bit per cycle, rounds to nearest-even, and packs a
// bfloat16 word. Input and output use valid/ready handshakes, and only one
// operation is in flight at a time.
module bf16_norm_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+3:0]       in_sum,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic                   out_ovf,
  output logic                   out_unf
);

  // SW: sum width = carry + hidden + fraction + guard + sticky
  localparam int SW = MAN_W + 4;
  // XW: one extra exponent bit so that overflow past the all-ones code stays visible
  localparam int XW = EXP_W + 1;
  localparam int RW = EXP_W + MAN_W + 1;

  localparam logic [XW-1:0] EXP_ZERO = {XW{1'b0}};
  localparam logic [XW-1:0] EXP_ONE  = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [XW-1:0] EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [SW-1:0] SUM_ZERO = {SW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // Round-to-nearest-even decision: guard set, and either sticky or lsb set
  function automatic logic round_up_f(input logic [SW-1:0] sum);
    round_up_f = sum[1] & (sum[0] | sum[2]);
  endfunction

  // Signed zero word, used for zero results and for flush-to-zero
  function automatic logic [RW-1:0] zero_word_f(input logic sign);
    zero_word_f = {sign, {(EXP_W+MAN_W){1'b0}}};
  endfunction

  // Signed infinity word, used on overflow
  function automatic logic [RW-1:0] inf_word_f(input logic sign);
    inf_word_f = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  endfunction

  state_t          state_r, state_s;
  logic            sign_r, sign_s;
  logic [XW-1:0]   exp_r, exp_s;
  logic [SW-1:0]   sum_r, sum_s;
  logic [RW-1:0]   result_r, result_s;
  logic            ovf_r, ovf_s;
  logic            unf_r, unf_s;
  logic            valid_r;
  logic            ready_r;

  // Rounding datapath. These signals are only consumed in ROUND.
  logic            rnd_s;
  logic [SW-1:0]   sum_rnd_s;
  logic            rnd_carry_s;
  logic [XW-1:0]   exp_rnd_s;
  logic [MAN_W-1:0] frac_rnd_s;

  assign rnd_s       = round_up_f(sum_r);
  assign sum_rnd_s   = sum_r + {{(SW-3){1'b0}}, rnd_s, 2'b00};
  assign rnd_carry_s = sum_rnd_s[SW-1];
  assign exp_rnd_s   = exp_r + {{(XW-1){1'b0}}, rnd_carry_s};
  // A rounding carry leaves 1.000..., so the stored fraction is zero
  assign frac_rnd_s  = rnd_carry_s ? {MAN_W{1'b0}} : sum_rnd_s[SW-3:2];

  // Next-state and datapath update: capture, one normalize step, round, hold output
  always_comb begin
    state_s  = state_r;
    sign_s   = sign_r;
    exp_s    = exp_r;
    sum_s    = sum_r;
    result_s = result_r;
    ovf_s    = ovf_r;
    unf_s    = unf_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && ready_r) begin
          sign_s  = in_sign;
          exp_s   = {1'b0, in_exp};
          sum_s   = in_sum;
          ovf_s   = 1'b0;
          unf_s   = 1'b0;
          state_s = ST_NORM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_NORM: begin
        // A zero exponent can only be seen here on the first NORM cycle,
        // because a left shift always stops at exponent 1.
        if ((exp_r == EXP_ZERO) || (sum_r == SUM_ZERO)) begin
          result_s = zero_word_f(sign_r);
          unf_s    = (sum_r != SUM_ZERO);
          state_s  = ST_OUT;
        end else if (exp_r == EXP_MAX) begin
          // inf/NaN exponent passes through without rounding
          result_s = {sign_r, exp_r[EXP_W-1:0], sum_r[SW-3:2]};
          state_s  = ST_OUT;
        end else if (sum_r[SW-1]) begin
          // Carry out: shift right and fold the dropped bit into sticky
          sum_s   = {1'b0, sum_r[SW-1:2], sum_r[1] | sum_r[0]};
          exp_s   = exp_r + EXP_ONE;
          state_s = ST_ROUND;
        end else if (sum_r[SW-2]) begin
          state_s = ST_ROUND;
        end else if (exp_r == EXP_ONE) begin
          // Another left shift would go subnormal, so flush to zero instead
          result_s = zero_word_f(sign_r);
          unf_s    = 1'b1;
          state_s  = ST_OUT;
        end else begin
          sum_s   = {sum_r[SW-2:0], 1'b0};
          exp_s   = exp_r - EXP_ONE;
          state_s = ST_NORM;
        end
      end
      ST_ROUND: begin
        if (exp_rnd_s >= EXP_MAX) begin
          result_s = inf_word_f(sign_r);
          ovf_s    = 1'b1;
        end else begin
          result_s = {sign_r, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
        end
        state_s = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs, with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sign_r   <= 1'b0;
      exp_r    <= EXP_ZERO;
      sum_r    <= SUM_ZERO;
      result_r <= {RW{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_s;
      sign_r   <= sign_s;
      exp_r    <= exp_s;
      sum_r    <= sum_s;
      result_r <= result_s;
      ovf_r    <= ovf_s;
      unf_r    <= unf_s;
      valid_r  <= (state_s == ST_OUT);
      ready_r  <= (state_s == ST_IDLE);
    end
  end

  assign in_ready   = ready_r;
  assign out_valid  = valid_r;
  assign out_result = result_r;
  assign out_ovf    = ovf_r;
  assign out_unf    = unf_r;

endmodule
